// File: rtl/cam_pkg.sv
// Shared encodings for the CAM write-side controller: ops, response status, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cam_pkg;

  localparam logic OP_INSERT = 1'b0;
  localparam logic OP_DELETE = 1'b1;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_DUP      = 2'd1;
  localparam logic [1:0] ST_FULL     = 2'd2;
  localparam logic [1:0] ST_NOTFOUND = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/cam_shadow_mem.sv
// Shadow copy of CAM keys plus valid vector; async read, sync write, bulk valid clear.
// Latency: read is combinational, write lands on the next rising edge.
// Backpressure: none; the owner sequences all accesses.
module cam_shadow_mem
  import cam_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int ram_depth  = 1 << addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_all,
  input  logic [addr_width-1:0] rd_addr,
  output logic [data_width-1:0] rd_key,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [data_width-1:0] wr_key,
  input  logic                  wr_valid
);

  logic [data_width-1:0] key_mem [ram_depth];
  logic [ram_depth-1:0]  valid_q;

  assign rd_key   = key_mem[rd_addr];
  assign rd_valid = valid_q[rd_addr];

  // Key storage is never reset; a slot's key only matters while its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      key_mem[wr_addr] <= wr_key;
    end
  end

  // Valid vector: cleared by reset or bulk clear, otherwise follows the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_addr] <= wr_valid;
    end
  end

endmodule

// File: rtl/cam_update_ctrl.sv
// CAM write-side controller: insert/delete with duplicate check, lowest-free allocation, entry count.
// Latency: accept, then one scan cycle per entry up to the decision, optional commit cycle, one response cycle.
// Backpressure: req_ready only in IDLE with clr low; one request in flight, responses are never stalled.
module cam_update_ctrl
  import cam_pkg::*;
#(
  parameter int data_width = 8,
  parameter int addr_width = 4,
  parameter int ram_depth  = 1 << addr_width
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [data_width-1:0] req_key,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic [addr_width-1:0] rsp_addr,
  output logic                  wr_en,
  output logic [addr_width-1:0] wr_addr,
  output logic [data_width-1:0] wr_data,
  output logic                  wr_valid,
  output logic [addr_width:0]   entry_count
);

  state_t                state_q, state_d;
  logic                  op_q, op_d;
  logic [data_width-1:0] key_q, key_d;
  logic [addr_width-1:0] idx_q, idx_d;
  logic                  free_vld_q, free_vld_d;
  logic [addr_width-1:0] free_idx_q, free_idx_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [1:0]            status_q, status_d;
  logic [addr_width:0]   count_q, count_d;

  logic                  mem_clr;
  logic [data_width-1:0] rd_key;
  logic                  rd_valid;
  logic                  hit;
  logic                  slot_free;
  logic                  last;

  cam_shadow_mem #(
    .data_width (data_width),
    .addr_width (addr_width),
    .ram_depth  (ram_depth)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_all  (mem_clr),
    .rd_addr  (idx_q),
    .rd_key   (rd_key),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_key   (wr_data),
    .wr_valid (wr_valid)
  );

  assign entry_count = count_q;

  // Next-state, datapath updates and all strobes/data outputs, decoded from the current state.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    key_d      = key_q;
    idx_d      = idx_q;
    free_vld_d = free_vld_q;
    free_idx_d = free_idx_q;
    addr_d     = addr_q;
    status_d   = status_q;
    count_d    = count_q;
    mem_clr    = 1'b0;
    req_ready  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    wr_valid   = 1'b0;
    rsp_valid  = 1'b0;
    rsp_status = '0;
    rsp_addr   = '0;

    hit       = rd_valid && (rd_key == key_q);
    slot_free = !rd_valid;
    last      = (idx_q == addr_width'(ram_depth - 1));

    case (state_q)
      IDLE: begin
        // rst_n gating keeps ready low while reset is held, since the FSM already sits in IDLE.
        req_ready = rst_n && !clr;
        if (clr) begin
          mem_clr = 1'b1;
          count_d = '0;
        end else if (req_valid) begin
          op_d       = req_op;
          key_d      = req_key;
          idx_d      = '0;
          free_vld_d = 1'b0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        // First invalid slot seen is the lowest free one.
        if (slot_free && !free_vld_q) begin
          free_vld_d = 1'b1;
          free_idx_d = idx_q;
        end
        if (hit) begin
          addr_d = idx_q;
          if (op_q == OP_INSERT) begin
            status_d = ST_DUP;
            state_d  = RESP;
          end else begin
            state_d = COMMIT;
          end
        end else if (last) begin
          if (op_q == OP_INSERT) begin
            // The last slot itself may be the only free one, so look at it directly too.
            if (free_vld_q || slot_free) begin
              addr_d  = free_vld_q ? free_idx_q : idx_q;
              state_d = COMMIT;
            end else begin
              status_d = ST_FULL;
              addr_d   = '0;
              state_d  = RESP;
            end
          end else begin
            status_d = ST_NOTFOUND;
            addr_d   = '0;
            state_d  = RESP;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      COMMIT: begin
        wr_en    = 1'b1;
        wr_addr  = addr_q;
        wr_data  = key_q;
        wr_valid = (op_q == OP_INSERT);
        status_d = ST_OK;
        count_d  = (op_q == OP_INSERT) ? count_q + 1'b1 : count_q - 1'b1;
        state_d  = RESP;
      end

      RESP: begin
        rsp_valid  = 1'b1;
        rsp_status = status_q;
        rsp_addr   = addr_q;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight request and its write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_INSERT;
      key_q      <= '0;
      idx_q      <= '0;
      free_vld_q <= 1'b0;
      free_idx_q <= '0;
      addr_q     <= '0;
      status_q   <= ST_OK;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      key_q      <= key_d;
      idx_q      <= idx_d;
      free_vld_q <= free_vld_d;
      free_idx_q <= free_idx_d;
      addr_q     <= addr_d;
      status_q   <= status_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_cam_update_ctrl.sv
// Bench for cam_update_ctrl: directed vector table, clear/reset sequences, random ops against a table model.
// Latency: measured per request in cycles after the accepting edge.
// Backpressure: waits on req_ready before each request.
module tb_cam_update_ctrl;
  import cam_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [DW-1:0] req_key;
  logic          rsp_valid;
  logic [1:0]    rsp_status;
  logic [AW-1:0] rsp_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic [AW:0]   entry_count;

  cam_update_ctrl #(.data_width(DW), .addr_width(AW), .ram_depth(D)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_key     (req_key),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_addr    (rsp_addr),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .entry_count (entry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       op;
    logic [7:0] key;
    logic [1:0] st;
    logic [3:0] addr;
    bit         wr;
    int         wr_lat;
    int         rsp_lat;
    int         cnt;
  } vec_t;

  int n_pass = 0;
  int n_chk  = 0;

  // Reference table: plain arrays searched linearly, latencies from the documented formulas.
  logic [7:0] mkey [D];
  bit         mval [D];
  int         mcnt;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  function automatic vec_t mkv(logic op, logic [7:0] key, logic [1:0] st, logic [3:0] addr,
                               bit wr, int wr_lat, int rsp_lat, int cnt);
    vec_t v;
    v.op = op; v.key = key; v.st = st; v.addr = addr;
    v.wr = wr; v.wr_lat = wr_lat; v.rsp_lat = rsp_lat; v.cnt = cnt;
    return v;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < D; i++) mval[i] = 1'b0;
    mcnt = 0;
  endfunction

  function automatic vec_t model_step(logic op, logic [7:0] key);
    vec_t v;
    int hit = -1;
    int fr  = -1;
    for (int i = 0; i < D; i++) if (hit < 0 && mval[i] && mkey[i] == key) hit = i;
    for (int i = 0; i < D; i++) if (fr < 0 && !mval[i]) fr = i;
    if (op == OP_INSERT) begin
      if (hit >= 0) v = mkv(op, key, ST_DUP, 4'(hit), 0, 0, hit + 2, mcnt);
      else if (fr >= 0) begin
        mval[fr] = 1'b1; mkey[fr] = key; mcnt++;
        v = mkv(op, key, ST_OK, 4'(fr), 1, D + 1, D + 2, mcnt);
      end else v = mkv(op, key, ST_FULL, 4'd0, 0, 0, D + 1, mcnt);
    end else begin
      if (hit >= 0) begin
        mval[hit] = 1'b0; mcnt--;
        v = mkv(op, key, ST_OK, 4'(hit), 1, hit + 2, hit + 3, mcnt);
      end else v = mkv(op, key, ST_NOTFOUND, 4'd0, 0, 0, D + 1, mcnt);
    end
    return v;
  endfunction

  // Issue one request and watch both strobes until the response (bounded).
  task automatic run_vec(input vec_t v, input string tag);
    int n = 0;
    int rsp_lat = -1;
    int wr_cnt = 0;
    int wr_lat = -1;
    int noise = 0;
    logic [1:0] st = 2'd0;
    logic [3:0] ra = 4'd0;
    logic [3:0] wa = 4'd0;
    logic [7:0] wd = 8'd0;
    logic       wv = 1'b0;
    while (req_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; req_op = v.op; req_key = v.key;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (wr_en) begin
        wr_cnt++; wr_lat = c; wa = wr_addr; wd = wr_data; wv = wr_valid;
      end else if (wr_addr != 0 || wr_data != 0 || wr_valid) noise++;
      if (rsp_valid) begin
        st = rsp_status; ra = rsp_addr; rsp_lat = c;
        break;
      end else if (rsp_status != 0 || rsp_addr != 0) noise++;
    end
    chk({tag, " rsp_lat"}, rsp_lat, v.rsp_lat);
    chk({tag, " status"}, int'(st), int'(v.st));
    chk({tag, " rsp_addr"}, int'(ra), int'(v.addr));
    chk({tag, " wr_pulses"}, wr_cnt, v.wr ? 1 : 0);
    if (v.wr) begin
      chk({tag, " wr_lat"}, wr_lat, v.wr_lat);
      chk({tag, " wr_addr"}, int'(wa), int'(v.addr));
      chk({tag, " wr_data"}, int'(wd), int'(v.key));
      chk({tag, " wr_valid"}, int'(wv), (v.op == OP_INSERT) ? 1 : 0);
    end
    chk({tag, " count"}, int'(entry_count), v.cnt);
    chk({tag, " idle_zero"}, noise, 0);
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    int stray;
    rst_n = 1'b0; clr = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_key = '0;
    model_clear();

    // Directed table: expected values written out by hand.
    vecs.push_back(mkv(OP_INSERT, 8'h5A, ST_OK,       4'd0,  1, 17, 18, 1));
    vecs.push_back(mkv(OP_INSERT, 8'h5A, ST_DUP,      4'd0,  0, 0,  2,  1));
    vecs.push_back(mkv(OP_DELETE, 8'h5A, ST_OK,       4'd0,  1, 2,  3,  0));
    for (int i = 0; i < D; i++)
      vecs.push_back(mkv(OP_INSERT, 8'(i), ST_OK, 4'(i), 1, 17, 18, i + 1));
    vecs.push_back(mkv(OP_INSERT, 8'h77, ST_FULL,     4'd0,  0, 0,  17, 16));
    vecs.push_back(mkv(OP_DELETE, 8'h03, ST_OK,       4'd3,  1, 5,  6,  15));
    vecs.push_back(mkv(OP_INSERT, 8'h99, ST_OK,       4'd3,  1, 17, 18, 16));
    vecs.push_back(mkv(OP_INSERT, 8'h0F, ST_DUP,      4'd15, 0, 0,  17, 16));
    vecs.push_back(mkv(OP_DELETE, 8'h0A, ST_OK,       4'd10, 1, 12, 13, 15));
    vecs.push_back(mkv(OP_DELETE, 8'hEE, ST_NOTFOUND, 4'd0,  0, 0,  17, 15));
    vecs.push_back(mkv(OP_INSERT, 8'hAB, ST_OK,       4'd10, 1, 17, 18, 16));
    vecs.push_back(mkv(OP_DELETE, 8'h0F, ST_OK,       4'd15, 1, 17, 18, 15));
    vecs.push_back(mkv(OP_INSERT, 8'hCD, ST_OK,       4'd15, 1, 17, 18, 16));

    // Reset state.
    #12;
    chk("rst ready", int'(req_ready), 0);
    chk("rst count", int'(entry_count), 0);
    chk("rst strobes", int'({wr_en, rsp_valid}), 0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("post_rst ready", int'(req_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = model_step(vecs[i].op, vecs[i].key);
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Clear in IDLE: blocks ready, empties the table on the next edge.
    @(negedge clk) clr = 1'b1;
    #1 chk("clr ready", int'(req_ready), 0);
    @(negedge clk) clr = 1'b0;
    model_clear();
    chk("clr count", int'(entry_count), 0);
    run_vec(model_step(OP_INSERT, 8'h42), "after_clr");

    // Reset in the middle of a scan.
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_INSERT; req_key = 8'h33;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst ready", int'(req_ready), 0);
    chk("midrst count", int'(entry_count), 0);
    chk("midrst wr", int'({wr_en, wr_valid, wr_addr, wr_data}), 0);
    chk("midrst rsp", int'({rsp_valid, rsp_status, rsp_addr}), 0);
    @(negedge clk) rst_n = 1'b1;
    model_clear();
    #1;
    chk("relrst ready", int'(req_ready), 1);
    chk("relrst count", int'(entry_count), 0);
    stray = 0;
    repeat (25) begin
      @(negedge clk);
      if (wr_en || rsp_valid) stray++;
    end
    chk("relrst stray", stray, 0);
    run_vec(model_step(OP_INSERT, 8'h33), "after_rst");

    // Random traffic over a small key space so duplicates, hits, FULL and NOTFOUND all occur.
    for (int i = 0; i < 80; i++) begin
      logic       op;
      logic [7:0] key;
      op  = ($urandom_range(0, 2) == 0) ? OP_DELETE : OP_INSERT;
      key = 8'($urandom_range(0, 23));
      run_vec(model_step(op, key), $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
